// File: rtl/linebuf_pkg.sv
// Shared constants and types for the double-buffered scanline buffer and its controller.
package linebuf_pkg;
  localparam int unsigned LB_IDX_W    = 9;
  localparam int unsigned LB_COLOR_W  = 6;
  localparam int unsigned LB_DATA_W   = 8;
  localparam int unsigned LB_PRIO_BIT = 6;

  typedef enum logic [1:0] {IDLE, CLEAR, RENDER, SPR_WR} lb_state_e;

  typedef struct packed {
    logic [LB_IDX_W-1:0]   idx;
    logic [LB_COLOR_W-1:0] data;
    logic                  prio;
  } lb_spr_req_t;

  // Stored pixel byte: [5:0] colour, [6] tile-priority flag, [7] reserved zero.
  function automatic logic [LB_DATA_W-1:0] lb_pixel(input logic prio,
                                                    input logic [LB_COLOR_W-1:0] color);
    return {1'b0, prio, color};
  endfunction
endpackage

// File: rtl/linebuf_ctrl_if.sv
// Renderer request handshakes plus the render-side port of the line buffer.
interface linebuf_ctrl_if;
  import linebuf_pkg::*;

  logic                  tile_valid;
  logic                  tile_ready;
  logic [LB_IDX_W-1:0]   tile_idx;
  logic [LB_COLOR_W-1:0] tile_data;
  logic                  tile_prio;

  logic                  spr_valid;
  logic                  spr_ready;
  logic [LB_IDX_W-1:0]   spr_idx;
  logic [LB_COLOR_W-1:0] spr_data;
  logic                  spr_prio;

  logic                  linesel;
  logic [LB_IDX_W-1:0]   idx1;
  logic [LB_DATA_W-1:0]  wrdata1;
  logic                  wren1;
  logic [LB_DATA_W-1:0]  rddata1;

  modport master (
    output tile_valid, tile_idx, tile_data, tile_prio,
    output spr_valid, spr_idx, spr_data, spr_prio,
    output rddata1,
    input  tile_ready, spr_ready, linesel, idx1, wrdata1, wren1
  );

  modport slave (
    input  tile_valid, tile_idx, tile_data, tile_prio,
    input  spr_valid, spr_idx, spr_data, spr_prio,
    input  rddata1,
    output tile_ready, spr_ready, linesel, idx1, wrdata1, wren1
  );
endinterface

// File: rtl/linebuf_ctrl.sv
// Scanline buffer sequencer: toggles halves per line, clears the render half,
// then arbitrates the single render port between tile writes and sprite read-modify-writes.
module linebuf_ctrl
  import linebuf_pkg::*;
#(
  parameter int unsigned LINE_W = 320
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          line_start,
  linebuf_ctrl_if.slave lb,
  output logic          busy,
  output logic          overrun,
  input  logic          overrun_clr
);
  localparam logic [LB_IDX_W-1:0] CLR_LAST = LB_IDX_W'(LINE_W - 1);

  lb_state_e           state, state_n;
  logic [LB_IDX_W-1:0] clr_cnt, clr_cnt_n;
  logic                linesel;
  lb_spr_req_t         spr_q;

  logic                 spr_take_c;
  logic                 spr_wr_en_c;
  logic                 tile_ready_c;
  logic                 spr_ready_c;
  logic                 wren1_c;
  logic [LB_IDX_W-1:0]  idx1_c;
  logic [LB_DATA_W-1:0] wrdata1_c;

  // Transparent sprites never write; a prio-flagged tile pixel is only covered by a prio sprite.
  assign spr_wr_en_c = (spr_q.data != '0) && !(lb.rddata1[LB_PRIO_BIT] && !spr_q.prio);

  always_comb begin
    state_n      = state;
    clr_cnt_n    = clr_cnt;
    spr_take_c   = 1'b0;
    tile_ready_c = 1'b0;
    spr_ready_c  = 1'b0;
    wren1_c      = 1'b0;
    idx1_c       = '0;
    wrdata1_c    = '0;

    unique case (state)
      IDLE: ;
      CLEAR: begin
        idx1_c  = clr_cnt;
        wren1_c = 1'b1;
        if (clr_cnt == CLR_LAST) state_n = RENDER;
        else                     clr_cnt_n = clr_cnt + LB_IDX_W'(1);
      end
      RENDER: begin
        // A line start blocks new grants; the requester retries after the clear.
        if (!line_start) begin
          if (lb.tile_valid) begin
            tile_ready_c = 1'b1;
            idx1_c       = lb.tile_idx;
            wrdata1_c    = lb_pixel(lb.tile_prio, lb.tile_data);
            wren1_c      = 1'b1;
          end else if (lb.spr_valid) begin
            spr_ready_c = 1'b1;
            spr_take_c  = 1'b1;
            idx1_c      = lb.spr_idx;
            state_n     = SPR_WR;
          end
        end
      end
      SPR_WR: begin
        idx1_c    = spr_q.idx;
        wrdata1_c = lb_pixel(1'b0, spr_q.data);
        wren1_c   = spr_wr_en_c;
        state_n   = RENDER;
      end
      default: state_n = IDLE;
    endcase

    if (line_start) begin
      state_n   = CLEAR;
      clr_cnt_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      clr_cnt <= '0;
      linesel <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
      spr_q   <= '0;
    end else begin
      state   <= state_n;
      clr_cnt <= clr_cnt_n;
      busy    <= (state_n == CLEAR);
      if (line_start) linesel <= ~linesel;
      if (spr_take_c) spr_q <= '{idx: lb.spr_idx, data: lb.spr_data, prio: lb.spr_prio};
      // A new line arriving mid-clear is flagged; the set takes precedence over the clear.
      if (line_start && (state == CLEAR)) overrun <= 1'b1;
      else if (overrun_clr)               overrun <= 1'b0;
    end
  end

  assign lb.tile_ready = tile_ready_c;
  assign lb.spr_ready  = spr_ready_c;
  assign lb.idx1       = idx1_c;
  assign lb.wrdata1    = wrdata1_c;
  assign lb.wren1      = wren1_c;
  assign lb.linesel    = linesel;
endmodule

// File: tb/tb_linebuf_ctrl.sv
// Self-checking bench for linebuf_ctrl: line buffer model plus a pixel-level reference model.
module tb_linebuf_ctrl;
  localparam int unsigned LINE_W = 320;

  logic clk = 1'b0;
  logic reset, line_start, overrun_clr;
  logic busy, overrun;

  linebuf_ctrl_if bif();

  linebuf_ctrl #(.LINE_W(LINE_W)) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .lb(bif),
    .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  logic [7:0] lb_mem  [2][512];
  logic [7:0] ref_pix [2][512];
  bit         ref_sel;
  int         n_cmp, n_err;

  // Line buffer model: synchronous write, registered read (data one cycle after address).
  always @(posedge clk) begin
    if (reset) begin
      for (int h = 0; h < 2; h++)
        for (int i = 0; i < 512; i++) lb_mem[h][i] <= 8'h00;
      bif.rddata1 <= 8'h00;
    end else begin
      if (bif.wren1) lb_mem[bif.linesel][bif.idx1] <= bif.wrdata1;
      bif.rddata1 <= lb_mem[bif.linesel][bif.idx1];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit spr_writes(input logic [7:0] old, input logic [5:0] d, input logic p);
    return (d != 6'd0) && !(old[6] && !p);
  endfunction

  function automatic int mem_diffs(input bit h);
    int n = 0;
    for (int i = 0; i < 512; i++) if (lb_mem[h][i] !== ref_pix[h][i]) n++;
    return n;
  endfunction

  task automatic ref_line_start();
    ref_sel = ~ref_sel;
    for (int i = 0; i < int'(LINE_W); i++) ref_pix[ref_sel][i] = 8'h00;
  endtask

  task automatic do_tile(input logic [8:0] i, input logic [5:0] d, input logic p, output bit ok);
    bif.tile_valid = 1'b1; bif.tile_idx = i; bif.tile_data = d; bif.tile_prio = p;
    #1;
    ok = bif.tile_ready;
    if (ok) ref_pix[ref_sel][i] = {1'b0, p, d};
    step();
    bif.tile_valid = 1'b0;
  endtask

  task automatic do_spr(input logic [8:0] i, input logic [5:0] d, input logic p,
                        output bit ok, output bit wr);
    bif.spr_valid = 1'b1; bif.spr_idx = i; bif.spr_data = d; bif.spr_prio = p;
    #1;
    ok = bif.spr_ready;
    step();
    bif.spr_valid = 1'b0;
    #1;
    wr = bif.wren1;
    if (ok && spr_writes(ref_pix[ref_sel][i], d, p)) ref_pix[ref_sel][i] = {2'b00, d};
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; line_start = 1'b0; overrun_clr = 1'b0;
    bif.tile_valid = 1'b0; bif.spr_valid = 1'b0;
    bif.tile_idx = '0; bif.tile_data = '0; bif.tile_prio = 1'b0;
    bif.spr_idx = '0; bif.spr_data = '0; bif.spr_prio = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    bif.tile_valid = 1'b1; bif.spr_valid = 1'b1; bif.tile_idx = 9'd33; bif.spr_idx = 9'd44;
    #1;
    n_cmp++;
    if ({bif.linesel, busy, overrun} !== 3'b000) begin
      n_err++; $display("FAIL reset_regs: linesel/busy/overrun=%b want 000", {bif.linesel, busy, overrun});
    end
    n_cmp++;
    if ({bif.tile_ready, bif.spr_ready, bif.wren1} !== 3'b000) begin
      n_err++; $display("FAIL idle_ctrl: tile_ready/spr_ready/wren1=%b want 000",
                        {bif.tile_ready, bif.spr_ready, bif.wren1});
    end
    n_cmp++;
    if ({bif.idx1, bif.wrdata1} !== 17'd0) begin
      n_err++; $display("FAIL idle_bus: idx1=%0d wrdata1=%h want 0/00", bif.idx1, bif.wrdata1);
    end
    step();
  endtask

  task automatic test_clear();
    bit ok;
    line_start = 1'b1;
    #1;
    n_cmp++;
    if ({bif.tile_ready, bif.spr_ready} !== 2'b00) begin
      n_err++; $display("FAIL ls_ready: readies=%b want 00", {bif.tile_ready, bif.spr_ready});
    end
    ref_line_start();
    step();
    line_start = 1'b0;
    #1;
    n_cmp++;
    if (bif.linesel !== ref_sel) begin
      n_err++; $display("FAIL linesel_toggle: got %b want %b", bif.linesel, ref_sel);
    end
    for (int i = 0; i < int'(LINE_W); i++) begin
      n_cmp++;
      if ({busy, bif.wren1, bif.wrdata1, bif.idx1, bif.tile_ready, bif.spr_ready} !==
          {1'b1, 1'b1, 8'h00, 9'(i), 2'b00}) begin
        n_err++; $display("FAIL clear_cycle %0d: busy=%b wren1=%b wrdata1=%h idx1=%0d readies=%b",
                          i, busy, bif.wren1, bif.wrdata1, bif.idx1, {bif.tile_ready, bif.spr_ready});
      end
      step();
      if (i == int'(LINE_W) - 1) begin bif.tile_valid = 1'b0; bif.spr_valid = 1'b0; end
    end
    #1;
    n_cmp++;
    if ({busy, bif.wren1} !== 2'b00) begin
      n_err++; $display("FAIL clear_done: busy/wren1=%b want 00", {busy, bif.wren1});
    end
    do_tile(9'd100, 6'h2A, 1'b0, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL first_grant: tile_ready=%b want 1", ok); end
    n_cmp++;
    if (mem_diffs(ref_sel) != 0) begin
      n_err++; $display("FAIL clear_mem: %0d pixels differ want 0", mem_diffs(ref_sel));
    end
  endtask

  task automatic test_arbitration();
    logic [7:0] exp_px;
    logic [8:0] si;
    logic [5:0] sd;
    logic       sp;
    bit         exp_w;
    si = 9'($urandom_range(0, 511)); sd = 6'($urandom_range(1, 63)); sp = 1'($urandom);
    bif.spr_valid = 1'b1; bif.spr_idx = si; bif.spr_data = sd; bif.spr_prio = sp;
    bif.tile_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bif.tile_idx  = (c == 0) ? si : 9'($urandom_range(0, 511));
      bif.tile_data = 6'($urandom);
      bif.tile_prio = 1'($urandom);
      #1;
      exp_px = {1'b0, bif.tile_prio, bif.tile_data};
      n_cmp++;
      if ({bif.tile_ready, bif.spr_ready, bif.wren1, bif.idx1, bif.wrdata1} !==
          {3'b101, bif.tile_idx, exp_px}) begin
        n_err++; $display("FAIL both_valid %0d: ready t/s=%b%b wren1=%b idx1=%0d wrdata1=%h want 1/0/1/%0d/%h",
                          c, bif.tile_ready, bif.spr_ready, bif.wren1, bif.idx1, bif.wrdata1, bif.tile_idx, exp_px);
      end
      ref_pix[ref_sel][bif.tile_idx] = exp_px;
      step();
    end
    bif.tile_valid = 1'b0;
    #1;
    n_cmp++;
    if ({bif.spr_ready, bif.wren1, bif.idx1} !== {2'b10, si}) begin
      n_err++; $display("FAIL spr_read: spr_ready=%b wren1=%b idx1=%0d want 1/0/%0d",
                        bif.spr_ready, bif.wren1, bif.idx1, si);
    end
    exp_w = spr_writes(ref_pix[ref_sel][si], sd, sp);
    if (exp_w) ref_pix[ref_sel][si] = {2'b00, sd};
    step();
    bif.spr_valid = 1'b0;
    bif.tile_valid = 1'b1;
    #1;
    n_cmp++;
    if ({bif.tile_ready, bif.spr_ready, bif.wren1, bif.idx1, bif.wrdata1} !==
        {2'b00, exp_w, si, {2'b00, sd}}) begin
      n_err++; $display("FAIL spr_write: readies=%b wren1=%b idx1=%0d wrdata1=%h want 00/%b/%0d/%h",
                        {bif.tile_ready, bif.spr_ready}, bif.wren1, bif.idx1, bif.wrdata1, exp_w, si, {2'b00, sd});
    end
    bif.tile_valid = 1'b0;
    step();
  endtask

  task automatic test_priority();
    bit ok, ok2, wr;
    do_tile(9'd5, 6'h12, 1'b1, ok);
    do_spr(9'd5, 6'h3F, 1'b0, ok2, wr);
    n_cmp++;
    if ({ok, ok2, wr, lb_mem[ref_sel][5]} !== {3'b110, 8'h52}) begin
      n_err++; $display("FAIL prio_block: grants=%b%b wren1=%b pixel=%h want 11/0/52", ok, ok2, wr, lb_mem[ref_sel][5]);
    end
    do_spr(9'd5, 6'h3F, 1'b1, ok2, wr);
    n_cmp++;
    if ({ok2, wr, lb_mem[ref_sel][5]} !== {2'b11, 8'h3F}) begin
      n_err++; $display("FAIL prio_override: grant=%b wren1=%b pixel=%h want 1/1/3f", ok2, wr, lb_mem[ref_sel][5]);
    end
    do_tile(9'd7, 6'h05, 1'b0, ok);
    do_spr(9'd7, 6'h00, 1'b1, ok2, wr);
    n_cmp++;
    if ({wr, lb_mem[ref_sel][7]} !== {1'b0, 8'h05}) begin
      n_err++; $display("FAIL transparent: wren1=%b pixel=%h want 0/05", wr, lb_mem[ref_sel][7]);
    end
  endtask

  task automatic test_random();
    bit tv = 1'b0, sv = 1'b0, in_wr = 1'b0, exp_w = 1'b0, exp_t, exp_s;
    for (int c = 0; c < 400; c++) begin
      if (!tv && $urandom_range(0, 99) < 40) begin
        tv = 1'b1; bif.tile_idx = 9'($urandom_range(0, 511));
        bif.tile_data = 6'($urandom); bif.tile_prio = 1'($urandom);
      end
      if (!sv && $urandom_range(0, 99) < 60) begin
        sv = 1'b1; bif.spr_idx = 9'($urandom_range(0, 63));
        bif.spr_data = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
        bif.spr_prio = 1'($urandom);
      end
      bif.tile_valid = tv; bif.spr_valid = sv;
      #1;
      exp_t = tv && !in_wr;
      exp_s = sv && !tv && !in_wr;
      n_cmp++;
      if ({bif.tile_ready, bif.spr_ready} !== {exp_t, exp_s}) begin
        n_err++; $display("FAIL rand_grant %0d: readies=%b%b want %b%b", c, bif.tile_ready, bif.spr_ready, exp_t, exp_s);
      end
      if (in_wr) begin
        n_cmp++;
        if (bif.wren1 !== exp_w) begin
          n_err++; $display("FAIL rand_spr_wren %0d: wren1=%b want %b", c, bif.wren1, exp_w);
        end
      end
      in_wr = 1'b0;
      if (exp_t) begin
        ref_pix[ref_sel][bif.tile_idx] = {1'b0, bif.tile_prio, bif.tile_data};
        tv = 1'b0;
      end
      if (exp_s) begin
        exp_w = spr_writes(ref_pix[ref_sel][bif.spr_idx], bif.spr_data, bif.spr_prio);
        if (exp_w) ref_pix[ref_sel][bif.spr_idx] = {2'b00, bif.spr_data};
        sv = 1'b0; in_wr = 1'b1;
      end
      step();
    end
    bif.tile_valid = 1'b0; bif.spr_valid = 1'b0;
    step();
    n_cmp++;
    if (mem_diffs(ref_sel) != 0) begin
      n_err++; $display("FAIL rand_mem: %0d pixels differ want 0", mem_diffs(ref_sel));
    end
  endtask

  task automatic test_overrun();
    line_start = 1'b1; bif.tile_valid = 1'b1; bif.tile_idx = 9'd9; bif.tile_data = 6'h11;
    #1;
    n_cmp++;
    if ({bif.tile_ready, bif.spr_ready, bif.wren1} !== 3'b000) begin
      n_err++; $display("FAIL ls_render: readies=%b wren1=%b want 00/0", {bif.tile_ready, bif.spr_ready}, bif.wren1);
    end
    ref_line_start();
    step();
    line_start = 1'b0; bif.tile_valid = 1'b0;
    repeat (100) step();
    line_start = 1'b1; overrun_clr = 1'b1;
    #1;
    n_cmp++;
    if ({bif.wren1, bif.idx1, overrun} !== {1'b1, 9'd100, 1'b0}) begin
      n_err++; $display("FAIL clear_at_100: wren1=%b idx1=%0d overrun=%b want 1/100/0", bif.wren1, bif.idx1, overrun);
    end
    ref_line_start();
    step();
    line_start = 1'b0; overrun_clr = 1'b0;
    #1;
    n_cmp++;
    if ({overrun, bif.linesel} !== {1'b1, ref_sel}) begin
      n_err++; $display("FAIL overrun_set: overrun=%b linesel=%b want 1/%b", overrun, bif.linesel, ref_sel);
    end
    for (int i = 0; i < int'(LINE_W); i++) begin
      n_cmp++;
      if ({busy, bif.wren1, bif.idx1} !== {2'b11, 9'(i)}) begin
        n_err++; $display("FAIL restart_clear %0d: busy=%b wren1=%b idx1=%0d", i, busy, bif.wren1, bif.idx1);
      end
      step();
    end
    n_cmp++;
    if ({busy, overrun} !== 2'b01) begin
      n_err++; $display("FAIL overrun_hold: busy/overrun=%b want 01", {busy, overrun});
    end
    n_cmp++;
    if (mem_diffs(ref_sel) != 0) begin
      n_err++; $display("FAIL restart_mem: %0d pixels differ want 0", mem_diffs(ref_sel));
    end
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    #1;
    n_cmp++;
    if (overrun !== 1'b0) begin n_err++; $display("FAIL overrun_clr: overrun=%b want 0", overrun); end
  endtask

  task automatic test_ls_sprwr();
    logic [8:0] si;
    logic [5:0] sd;
    bit         old_sel;
    si = 9'($urandom_range(0, 319)); sd = 6'($urandom_range(1, 63));
    bif.spr_valid = 1'b1; bif.spr_idx = si; bif.spr_data = sd; bif.spr_prio = 1'b1;
    #1;
    n_cmp++;
    if (bif.spr_ready !== 1'b1) begin n_err++; $display("FAIL lsw_grant: spr_ready=%b want 1", bif.spr_ready); end
    ref_pix[ref_sel][si] = {2'b00, sd};
    step();
    line_start = 1'b1; bif.tile_valid = 1'b1; bif.spr_idx = 9'd400;
    #1;
    n_cmp++;
    if ({bif.tile_ready, bif.spr_ready, bif.wren1, bif.idx1} !== {3'b001, si}) begin
      n_err++; $display("FAIL lsw_cycle: readies=%b wren1=%b idx1=%0d want 00/1/%0d",
                        {bif.tile_ready, bif.spr_ready}, bif.wren1, bif.idx1, si);
    end
    old_sel = ref_sel;
    ref_line_start();
    step();
    line_start = 1'b0; bif.tile_valid = 1'b0; bif.spr_valid = 1'b0;
    #1;
    n_cmp++;
    if (lb_mem[old_sel][si] !== {2'b00, sd}) begin
      n_err++; $display("FAIL lsw_old_half: pixel=%h want %h", lb_mem[old_sel][si], {2'b00, sd});
    end
    n_cmp++;
    if ({bif.linesel, busy, bif.wren1, bif.idx1} !== {ref_sel, 2'b11, 9'd0}) begin
      n_err++; $display("FAIL lsw_new_clear: linesel=%b busy=%b wren1=%b idx1=%0d want %b/1/1/0",
                        bif.linesel, busy, bif.wren1, bif.idx1, ref_sel);
    end
    repeat (LINE_W) step();
    n_cmp++;
    if (mem_diffs(ref_sel) != 0) begin
      n_err++; $display("FAIL lsw_mem: %0d pixels differ want 0", mem_diffs(ref_sel));
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0; ref_sel = 1'b0;
    for (int h = 0; h < 2; h++)
      for (int i = 0; i < 512; i++) ref_pix[h][i] = 8'h00;
    test_reset();
    test_clear();
    test_arbitration();
    test_priority();
    test_random();
    test_overrun();
    test_ls_sprwr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/linebuf_ctrl.md
# linebuf_ctrl

Sequencer and write-port arbiter for the double-buffered scanline buffer. Toggles the buffer half on every line start, clears the newly selected render half, then shares the single render-side read/write port between the tile renderer (single-cycle writes) and the sprite renderer (priority-checked read-modify-write). Sits between the video timing generator and the two renderers. Drives the `linesel`/`idx1`/`wrdata1`/`wren1` inputs of the line buffer and consumes its `rddata1`.

## Interface
Parameters:
- `LINE_W`, 320: pixels cleared per line; legal range 1..512.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high.
- `line_start`  in  1  one-cycle pulse at the start of each scanline.
- `tile_valid`  in  1  tile write request.
- `tile_ready`  out  1  tile request accepted this cycle.
- `tile_idx`  in  9  pixel index.
- `tile_data`  in  6  colour.
- `tile_prio`  in  1  tile-over-sprite flag.
- `spr_valid`  in  1  sprite write request.
- `spr_ready`  out  1  sprite request accepted this cycle.
- `spr_idx`  in  9  pixel index.
- `spr_data`  in  6  colour; 0 means transparent.
- `spr_prio`  in  1  sprite overrides tile priority.
- `linesel`  out  1  to line buffer.
- `idx1`  out  9  to line buffer.
- `wrdata1`  out  8  to line buffer.
- `wren1`  out  1  to line buffer.
- `rddata1`  in  8  from line buffer; valid 1 cycle after address.
- `busy`  out  1  high while clearing.
- `overrun`  out  1  sticky; set when a line start hits an unfinished clear.
- `overrun_clr`  in  1  clears `overrun`.

## Operation
- Stored byte format: [5:0] colour, [6] tile-priority flag, [7] always 0.
- States: IDLE, CLEAR, RENDER, SPR_WR.
- IDLE: on `line_start`, go to CLEAR.
- CLEAR: write 0 at `idx1` = clear counter, counting 0..LINE_W-1 with one write per cycle. After LINE_W-1, go to RENDER. `busy` = 1; both readies = 0.
- RENDER arbitration uses fixed priority, tile first:
  - `tile_valid`: `tile_ready` = 1. Write `{1'b0, tile_prio, tile_data}` at `tile_idx`. Stay in RENDER.
  - Otherwise, if `spr_valid`: `spr_ready` = 1. Drive `idx1` = `spr_idx` with `wren1` = 0 (read cycle). Latch idx, data and prio. Go to SPR_WR.
- SPR_WR: drive `idx1` = latched idx; `rddata1` holds the old pixel.
  - `wren1` = (data != 0) && !(`rddata1`[6] && !prio).
  - `wrdata1` = `{2'b00, data}`.
  - Both readies = 0. Return to RENDER.
- `line_start` from any state:
  - Takes effect the next cycle: `linesel` toggles, the clear counter resets to 0, and the state goes to CLEAR.
  - In the `line_start` cycle itself, both readies = 0. The current cycle's port action completes; an SPR_WR in that cycle still writes the old half.
- `line_start` while in CLEAR sets `overrun`; the clear restarts at 0 on the new half.
- `overrun_clr` and a set event in the same cycle: set wins.
- `tile_idx`/`spr_idx` >= LINE_W are written as given, with no range check.

## Timing
- `idx1`, `wrdata1`, `wren1` and both readies are combinational from state and requests. `linesel`, state, the clear counter, sprite latches and `overrun` are registered.
- Reset values: `linesel` 0, state IDLE, counter 0, `busy` 0, `overrun` 0.
- Outputs in IDLE: `wren1` 0, `idx1` 0, `wrdata1` 0, readies 0.
- Tile write: accepted and written in the same cycle; throughput 1 per cycle.
- Sprite write: 2 cycles (read, then conditional write); throughput 1 per 2 cycles, less under tile traffic.
- Clear duration: LINE_W cycles. The first render grant is possible at cycle LINE_W+1 after `line_start`.
- A requester holds valid and payload stable until ready; a request refused at `line_start` is simply retried.

## Structure
- Shared package `linebuf_pkg`:
  - `LB_PRIO_BIT` = 6.
  - State enum {IDLE, CLEAR, RENDER, SPR_WR}.
  - `LB_IDX_W` = 9.
- No sub-module. The parent instantiates `linebuf` next to this block and wires the ports directly.

## Test plan
- Reset, then `line_start` with LINE_W=320:
  - `linesel` goes 0→1.
  - 320 cycles of `wren1`=1 with `wrdata1`=0 at idx 0..319, with `busy` high.
  - Then `busy` low and RENDER.
- In RENDER, tile and sprite both valid every cycle: `tile_ready` every cycle, `spr_ready` never. Dropping `tile_valid` gives a sprite read, then a write the next cycle.
- Tile writes idx 5 colour 0x12 with prio=1, then sprite writes idx 5 colour 0x3F:
  - prio=0: no write; the pixel stays 0x52.
  - prio=1: written as 0x3F.
- Sprite writes colour 0 at idx 7 after a tile write of 0x05: no write; the pixel stays 0x05.
- `line_start` at clear count 100:
  - `overrun`=1 and `linesel` toggles.
  - The clear restarts at idx 0 and runs the full 320.
  - `overrun_clr` returns `overrun` to 0.
- `line_start` in the same cycle as SPR_WR: the write lands in the old half; no ready is asserted that cycle; the clear starts on the new half next cycle.
